multi_clock_divider: RTL and testbench

//  Parametrised N-channel programmable clock divider; successor to the single-channel 8-bit divider.

---
 rtl/multi_clock_divider_pkg.sv | 27 ++
 rtl/multi_clock_divider_if.sv | 33 +++
 rtl/multi_clock_divider_channel.sv | 135 +++++++++++++
 rtl/multi_clock_divider.sv | 45 ++++
 tb/tb_multi_clock_divider.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_clock_divider_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg: shared types for the multi-channel programmable clock divider.
//   mode_t  - output style of a channel (50% toggle clock or 1-cycle tick)
//   state_t - per-channel run state
// The {div, mode} configuration record depends on the divisor width, so each
// channel declares it locally from its WIDTH parameter.
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPING
    } state_t;

    // Supported parameter ranges.
    localparam int unsigned NCH_MIN   = 1;
    localparam int unsigned NCH_MAX   = 16;
    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/multi_clock_divider_if.sv
// -----------------------------------------------------------------------------
// multi_clock_divider_if: control/config/output bundle of the divider.
//   en[NCH]       per-channel run request
//   sync          phase-align all channels
//   cfg_we[NCH]   per-channel config write strobe
//   cfg_div       divisor written on cfg_we (shared)
//   cfg_mode      mode written on cfg_we (0=TOGGLE, 1=PULSE)
//   out[NCH]      divided outputs
//   pending[NCH]  shadow config written but not yet applied
// master = controller side, slave = divider side.
// -----------------------------------------------------------------------------
interface multi_clock_divider_if #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned WIDTH = 8
);
    logic [NCH-1:0]   en;
    logic             sync;
    logic [NCH-1:0]   cfg_we;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_mode;
    logic [NCH-1:0]   out;
    logic [NCH-1:0]   pending;

    modport master (
        output en, sync, cfg_we, cfg_div, cfg_mode,
        input  out, pending
    );

    modport slave (
        input  en, sync, cfg_we, cfg_div, cfg_mode,
        output out, pending
    );
endinterface

// File: rtl/multi_clock_divider_channel.sv
// -----------------------------------------------------------------------------
// div_channel: one divider channel (shadow config, counter, run FSM, out reg).
//   clk, reset      clock / async active-high reset
//   en              run request
//   sync            clear counter and output, apply pending config
//   cfg_we          load {cfg_div, cfg_mode} into the shadow register
//   cfg_div         divisor
//   cfg_mode        0=TOGGLE, 1=PULSE
//   out             divided output (registered)
//   pending         shadow written but not yet active
// -----------------------------------------------------------------------------
module div_channel
    import div_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_DIV = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_mode,
    output logic             out,
    output logic             pending
);

    typedef struct packed {
        logic [WIDTH-1:0] div;
        mode_t            mode;
    } div_cfg_t;

    localparam div_cfg_t RESET_CFG = '{div: WIDTH'(RESET_DIV), mode: MODE_TOGGLE};

    state_t           state;
    logic [WIDTH-1:0] cnt;
    div_cfg_t         act;
    div_cfg_t         shadow;

    div_cfg_t         wr_cfg;
    div_cfg_t         next_cfg;
    logic             has_new;
    logic             wrap;
    logic             wrap_out;

    always_comb begin
        wr_cfg   = '{div: cfg_div, mode: mode_t'(cfg_mode)};
        // A write landing in the same cycle as a boundary wins over the shadow.
        next_cfg = cfg_we ? wr_cfg : shadow;
        has_new  = cfg_we | pending;
        wrap     = (cnt == act.div);
        // A mode switch restarts the output from 0 so no runt level survives.
        if (has_new && (next_cfg.mode != act.mode)) begin
            wrap_out = 1'b0;
        end else if (act.mode == MODE_TOGGLE) begin
            wrap_out = ~out;
        end else begin
            wrap_out = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            out     <= 1'b0;
            pending <= 1'b0;
            act     <= RESET_CFG;
            shadow  <= RESET_CFG;
        end else begin
            if (cfg_we) begin
                shadow <= wr_cfg;
            end

            if (sync) begin
                cnt     <= '0;
                out     <= 1'b0;
                pending <= 1'b0;
                if (has_new) begin
                    act <= next_cfg;
                end
            end else if (state == ST_IDLE) begin
                // Idle is always a boundary: last cycle's write is applied now.
                cnt     <= '0;
                out     <= 1'b0;
                pending <= cfg_we;
                if (pending) begin
                    act <= shadow;
                end
                if (en) begin
                    state <= ST_RUN;
                end
            end else begin
                if (wrap) begin
                    cnt     <= '0;
                    out     <= wrap_out;
                    pending <= 1'b0;
                    if (has_new) begin
                        act <= next_cfg;
                    end
                end else begin
                    cnt     <= cnt + 1'b1;
                    pending <= pending | cfg_we;
                    if (act.mode == MODE_PULSE) begin
                        out <= 1'b0;
                    end
                end

                // A high toggle half-period is always completed before
                // idling; if it ends this very cycle, go straight to idle.
                if (state == ST_RUN) begin
                    if (!en) begin
                        if (!out || (act.mode == MODE_PULSE) || wrap) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                            out   <= 1'b0;
                        end else begin
                            state <= ST_STOPPING;
                        end
                    end
                end else begin
                    if (en) begin
                        state <= ST_RUN;
                    end else if (wrap) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        out   <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/multi_clock_divider.sv
// -----------------------------------------------------------------------------
// multi_clock_divider: NCH independent programmable clock dividers.
//   clk     system clock (rising edge)
//   reset   asynchronous, active-high
//   bus     multi_clock_divider_if.slave: en, sync, cfg_we, cfg_div,
//           cfg_mode in; out, pending out
// Each channel outputs a 50% toggle clock or a 1-cycle tick; config changes
// are shadowed and take effect only at a period boundary.
// -----------------------------------------------------------------------------
module multi_clock_divider
    import div_pkg::*;
#(
    parameter int unsigned NCH       = 2,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_DIV = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    multi_clock_divider_if.slave  bus
);

    logic [NCH-1:0] out_vec;
    logic [NCH-1:0] pending_vec;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        div_channel #(
            .WIDTH     (WIDTH),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (bus.en[i]),
            .sync     (bus.sync),
            .cfg_we   (bus.cfg_we[i]),
            .cfg_div  (bus.cfg_div),
            .cfg_mode (bus.cfg_mode),
            .out      (out_vec[i]),
            .pending  (pending_vec[i])
        );
    end

    assign bus.out     = out_vec;
    assign bus.pending = pending_vec;

endmodule

// File: tb/tb_multi_clock_divider.sv
module tb_multi_clock_divider;

    localparam int NCH   = 2;
    localparam int WIDTH = 8;
    localparam int RDIV  = 2;
    localparam int CAP   = 300;

    logic clk;
    logic reset;

    multi_clock_divider_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

    multi_clock_divider #(
        .NCH       (NCH),
        .WIDTH     (WIDTH),
        .RESET_DIV (RDIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.en       = '0;
        bus.sync     = 1'b0;
        bus.cfg_we   = '0;
        bus.cfg_div  = '0;
        bus.cfg_mode = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic write_cfg(input int ch, input int d, input int m);
        bus.cfg_div  = WIDTH'(d);
        bus.cfg_mode = m[0];
        bus.cfg_we   = NCH'(1) << ch;
        step();
        bus.cfg_we   = '0;
    endtask

    // Consecutive samples at 'level', bounded by cap.
    task automatic run_len(input int ch, input logic level, input int cap, output int n);
        n = 0;
        while (n < cap && bus.out[ch] === level) begin
            n++;
            step();
        end
    endtask

    // Edges until out[ch] goes high, bounded by cap.
    task automatic wait_rise(input int ch, input int cap, output int n);
        n = 0;
        while (n < cap && bus.out[ch] !== 1'b1) begin
            step();
            n++;
        end
    endtask

    // ---------------- reference model (closed form per period origin) -------
    // k = edges since last origin (run start, sync or config apply);
    // o0 = output level at that origin.
    int mk[NCH], mo0[NCH], md[NCH], mm[NCH], mpend[NCH], msd[NCH], msm[NCH];

    function automatic int mout(input int c);
        if (mm[c] == 0) return mo0[c] ^ ((mk[c] / (md[c] + 1)) & 1);
        if (mk[c] == 0) return mo0[c];
        return (mk[c] % (md[c] + 1) == 0) ? 1 : 0;
    endfunction

    function automatic void model_edge(input int c, input int we, input int sy, input int d, input int m);
        int prev;
        int kn;
        prev = mout(c);
        if (we != 0) begin
            msd[c] = d;
            msm[c] = m;
        end
        if (sy != 0) begin
            if (we != 0 || mpend[c] != 0) begin
                md[c] = msd[c];
                mm[c] = msm[c];
            end
            mpend[c] = 0;
            mk[c]    = 0;
            mo0[c]   = 0;
        end else begin
            if (we != 0) mpend[c] = 1;
            kn = mk[c] + 1;
            if (kn % (md[c] + 1) == 0 && mpend[c] != 0) begin
                if (msm[c] != mm[c]) mo0[c] = 0;
                else if (mm[c] == 0) mo0[c] = 1 - prev;
                else mo0[c] = 1;
                md[c]    = msd[c];
                mm[c]    = msm[c];
                mk[c]    = 0;
                mpend[c] = 0;
            end else begin
                mk[c] = kn;
            end
        end
    endfunction

    typedef struct {
        int div;
        int mode;
        int first;
        int hi;
        int lo;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int r0;
        int r1;
        logic [NCH-1:0] exp_out;
        logic [NCH-1:0] exp_pend;
        logic [NCH-1:0] we_bits;
        int sy;
        int rd;
        int rm;

        vecs[0] = '{div: 0,   mode: 0, first: 1,   hi: 1,   lo: 1};
        vecs[1] = '{div: 1,   mode: 0, first: 2,   hi: 2,   lo: 2};
        vecs[2] = '{div: 3,   mode: 0, first: 4,   hi: 4,   lo: 4};
        vecs[3] = '{div: 4,   mode: 1, first: 5,   hi: 1,   lo: 4};
        vecs[4] = '{div: 2,   mode: 1, first: 3,   hi: 1,   lo: 2};
        vecs[5] = '{div: 0,   mode: 1, first: 1,   hi: CAP, lo: 0};
        vecs[6] = '{div: 255, mode: 0, first: 256, hi: 256, lo: 256};

        // Reset state
        do_reset();
        reset = 1'b1;
        step();
        check("reset_out", 32'(bus.out), 0);
        check("reset_pending", 32'(bus.pending), 0);
        reset = 1'b0;
        step();

        // Table: single-channel waveform shapes
        for (int i = 0; i < 7; i++) begin
            do_reset();
            write_cfg(0, vecs[i].div, vecs[i].mode);
            check($sformatf("v%0d_pend_write", i), 32'(bus.pending[0]), 1);
            step();
            check($sformatf("v%0d_pend_idle", i), 32'(bus.pending[0]), 0);
            bus.en = 2'b01;
            step();
            wait_rise(0, CAP, n);
            check($sformatf("v%0d_first", i), n, vecs[i].first);
            run_len(0, 1'b1, CAP, n);
            check($sformatf("v%0d_high", i), n, vecs[i].hi);
            if (vecs[i].hi != CAP) begin
                run_len(0, 1'b0, CAP, n);
                check($sformatf("v%0d_low", i), n, vecs[i].lo);
            end
            check($sformatf("v%0d_pend_run", i), 32'(bus.pending[0]), 0);
            bus.en = '0;
        end

        // Divisor change mid half-period: current half kept, then new rate
        do_reset();
        write_cfg(0, 3, 0);
        step();
        bus.en = 2'b01;
        step();
        wait_rise(0, 20, n);
        step();
        write_cfg(0, 1, 0);
        check("t3_pend_set", 32'(bus.pending[0]), 1);
        run_len(0, 1'b1, 20, n);
        check("t3_cur_half", n + 2, 4);
        check("t3_pend_clr", 32'(bus.pending[0]), 0);
        run_len(0, 1'b0, 20, n);
        check("t3_low2", n, 2);
        run_len(0, 1'b1, 20, n);
        check("t3_high2", n, 2);
        run_len(0, 1'b0, 20, n);
        check("t3_low2b", n, 2);

        // Pulse channel 1 then switch to div=0 (constant high)
        do_reset();
        write_cfg(1, 4, 1);
        step();
        bus.en = 2'b10;
        step();
        wait_rise(1, 20, n);
        check("t4_first", n, 5);
        run_len(1, 1'b1, 20, n);
        check("t4_high", n, 1);
        run_len(1, 1'b0, 20, n);
        check("t4_low", n, 4);
        check("t4_ch0_idle", 32'(bus.out[0]), 0);
        step();
        write_cfg(1, 0, 1);
        check("t4_pend", 32'(bus.pending[1]), 1);
        wait_rise(1, 20, n);
        check("t4_apply_at_wrap", n, 3);
        check("t4_pend_clr", 32'(bus.pending[1]), 0);
        run_len(1, 1'b1, 12, n);
        check("t4_const_high", n, 12);

        // Stop request: high half completes, then idle; re-enable in STOPPING
        do_reset();
        write_cfg(0, 3, 0);
        step();
        bus.en = 2'b01;
        step();
        wait_rise(0, 20, n);
        step();
        bus.en = 2'b00;
        step();
        run_len(0, 1'b1, 20, n);
        check("t5_stop_high", n + 2, 4);
        run_len(0, 1'b0, 10, n);
        check("t5_idle_low", n, 10);
        bus.en = 2'b01;
        step();
        wait_rise(0, 20, n);
        check("t5_restart", n, 4);
        step();
        bus.en = 2'b00;
        step();
        bus.en = 2'b01;
        step();
        run_len(0, 1'b1, 20, n);
        check("t5_cancel_high", n + 3, 4);
        run_len(0, 1'b0, 20, n);
        check("t5_cancel_low", n, 4);
        run_len(0, 1'b1, 20, n);
        check("t5_cancel_high2", n, 4);

        // Sync alignment, sync held, async reset mid-high
        do_reset();
        write_cfg(0, 2, 0);
        write_cfg(1, 5, 0);
        step();
        bus.en = 2'b11;
        step();
        repeat (7) step();
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        check("t6_sync_clear", 32'(bus.out), 0);
        r0 = 0;
        r1 = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (bus.out[0] === 1'b1 && r0 == 0) r0 = k;
            if (bus.out[1] === 1'b1 && r1 == 0) r1 = k;
        end
        check("t6_rise_ch0", r0, 3);
        check("t6_rise_ch1", r1, 6);
        bus.sync = 1'b1;
        repeat (5) step();
        check("t6_sync_held", 32'(bus.out), 0);
        bus.sync = 1'b0;
        wait_rise(1, 20, n);
        write_cfg(1, 1, 0);
        check("t6_pend_before_rst", 32'(bus.pending[1]), 1);
        check("t6_high_before_rst", 32'(bus.out[1]), 1);
        reset = 1'b1;
        #1;
        check("t6_async_out", 32'(bus.out), 0);
        check("t6_async_pend", 32'(bus.pending), 0);
        step();
        step();
        reset = 1'b0;
        step();
        wait_rise(0, 20, n);
        check("t6_reset_div_ch0", n, RDIV + 1);
        check("t6_reset_div_ch1", 32'(bus.out[1]), 1);

        // Randomized run against the reference model
        for (int t = 0; t < 20; t++) begin
            do_reset();
            for (int c = 0; c < NCH; c++) begin
                md[c] = int'($urandom_range(0, 7));
                mm[c] = int'($urandom_range(0, 1));
                msd[c] = md[c];
                msm[c] = mm[c];
                write_cfg(c, md[c], mm[c]);
            end
            step();
            bus.en = '1;
            step();
            for (int c = 0; c < NCH; c++) begin
                mk[c] = 0;
                mo0[c] = 0;
                mpend[c] = 0;
            end
            for (int cyc = 0; cyc < 60; cyc++) begin
                sy = ($urandom_range(0, 29) == 0) ? 1 : 0;
                rd = int'($urandom_range(0, 7));
                rm = int'($urandom_range(0, 1));
                for (int c = 0; c < NCH; c++) we_bits[c] = ($urandom_range(0, 9) == 0);
                bus.sync     = sy[0];
                bus.cfg_we   = we_bits;
                bus.cfg_div  = WIDTH'(rd);
                bus.cfg_mode = rm[0];
                for (int c = 0; c < NCH; c++) model_edge(c, int'(we_bits[c]), sy, rd, rm);
                step();
                for (int c = 0; c < NCH; c++) begin
                    exp_out[c]  = mout(c) != 0;
                    exp_pend[c] = mpend[c] != 0;
                end
                check($sformatf("rand_t%0d_c%0d_out", t, cyc), 32'(bus.out), 32'(exp_out));
                check($sformatf("rand_t%0d_c%0d_pend", t, cyc), 32'(bus.pending), 32'(exp_pend));
            end
            bus.sync   = 1'b0;
            bus.cfg_we = '0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
